// File: rtl/enable_counter_pkg.sv
// Shared constants, count type and elaboration-time parameter check for enable_counter.
package enable_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

  // True when width is 1..32 and both step (nonzero) and reset value fit in width bits.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned step,
                                   input int unsigned reset_value);
    logic [63:0] lim;
    if (width < 1 || width > 32) return 1'b0;
    lim = 64'd1 << width;
    return (step != 0) && ({32'd0, step} < lim) && ({32'd0, reset_value} < lim);
  endfunction

endpackage

// File: rtl/enable_counter_core.sv
// Count register with synchronous reset and the enable-gated next-state adder.
module enable_counter_core #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] STEP_V  = 1,
  parameter logic [WIDTH-1:0] RESET_V = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Plain WIDTH-bit add: the carry is dropped, giving silent modulo wrap.
  assign w_next = r_count + STEP_V;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= RESET_V;
    end else if (i_enable) begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/enable_counter.sv
// Top: parameter validation and legacy port order (out, enable, clk, reset) around the core.
module enable_counter
  import enable_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned STEP        = 1,
  parameter int unsigned RESET_VALUE = 0
) (
  output logic [WIDTH-1:0] out,
  input  logic             enable,
  input  logic             clk,
  input  logic             reset
);

  if (!params_ok(WIDTH, STEP, RESET_VALUE)) begin : g_param_err
    $fatal(1, "enable_counter: illegal parameters WIDTH=%0d STEP=%0d RESET_VALUE=%0d",
           WIDTH, STEP, RESET_VALUE);
  end

  enable_counter_core #(
    .WIDTH   (WIDTH),
    .STEP_V  (WIDTH'(STEP)),
    .RESET_V (WIDTH'(RESET_VALUE))
  ) u_core (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_enable (enable),
    .o_count  (out)
  );

endmodule

// File: tb/tb_enable_counter.sv
// Self-checking bench: default counter plus WIDTH=4/STEP=3 and RESET_VALUE=200 variants.
module tb_enable_counter;
  import enable_counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0, enable = 1'b0;
  logic       r4 = 1'b0, e4 = 1'b0;
  logic       rr = 1'b0, er = 1'b0;
  count_t     out;
  logic [3:0] out4;
  logic [7:0] outr;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  enable_counter dut (.out(out), .enable(enable), .clk(clk), .reset(reset));

  enable_counter #(.WIDTH(4), .STEP(3)) dut4 (.out(out4), .enable(e4), .clk(clk), .reset(r4));

  enable_counter #(.RESET_VALUE(200)) dutr (.out(outr), .enable(er), .clk(clk), .reset(rr));

  // Advance n rising edges and land 4 ns after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #4;
  endtask

  task automatic test_count_run;
    #24 reset = 1'b1;
    #20 reset = 1'b0;
    #20 enable = 1'b1;
    #500;
    checks++;
    if (out !== 8'd25) begin
      errors++;
      $display("FAIL count_run: out=%0d expected=25 at t=%0t", out, $time);
    end
    cyc(1);
  endtask

  task automatic test_reset;
    enable = 1'b0;
    reset = 1'b1;
    cyc(2);
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL reset: out=%0d expected=0", out); end
    reset = 1'b0;
    cyc(20);
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL reset_idle: out=%0d expected=0", out); end
  endtask

  task automatic test_hold;
    reset = 1'b1; cyc(1);
    reset = 1'b0; enable = 1'b1; cyc(10);
    checks++;
    if (out !== 8'd10) begin errors++; $display("FAIL hold_count10: out=%0d expected=10", out); end
    enable = 1'b0; cyc(5);
    checks++;
    if (out !== 8'd10) begin errors++; $display("FAIL hold_idle: out=%0d expected=10", out); end
    enable = 1'b1; cyc(3);
    checks++;
    if (out !== 8'd13) begin errors++; $display("FAIL hold_resume: out=%0d expected=13", out); end
  endtask

  task automatic test_wrap;
    enable = 1'b0; reset = 1'b1; cyc(1);
    reset = 1'b0; enable = 1'b1; cyc(255);
    checks++;
    if (out !== 8'd255) begin errors++; $display("FAIL wrap_255: out=%0d expected=255", out); end
    cyc(1);
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL wrap_256: out=%0d expected=0", out); end
    cyc(1);
    checks++;
    if (out !== 8'd1) begin errors++; $display("FAIL wrap_257: out=%0d expected=1", out); end
  endtask

  task automatic test_simultaneous;
    enable = 1'b0; reset = 1'b1; cyc(1);
    reset = 1'b0; enable = 1'b1; cyc(100);
    checks++;
    if (out !== 8'd100) begin errors++; $display("FAIL sim_pre: out=%0d expected=100", out); end
    reset = 1'b1; cyc(1);
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL sim_reset_wins: out=%0d expected=0", out); end
    reset = 1'b0; cyc(1);
    checks++;
    if (out !== 8'd1) begin errors++; $display("FAIL sim_resume: out=%0d expected=1", out); end
  endtask

  task automatic test_variants;
    r4 = 1'b1; rr = 1'b1; e4 = 1'b1; er = 1'b1; cyc(1);
    checks++;
    if (out4 !== 4'd0) begin errors++; $display("FAIL w4_reset: out=%0d expected=0", out4); end
    checks++;
    if (outr !== 8'd200) begin errors++; $display("FAIL rv_reset: out=%0d expected=200", outr); end
    r4 = 1'b0; rr = 1'b0; cyc(6);
    checks++;
    if (out4 !== 4'd2) begin errors++; $display("FAIL w4_step3: out=%0d expected=2", out4); end
    cyc(94);
    checks++;
    if (outr !== 8'd44) begin errors++; $display("FAIL rv_wrap: out=%0d expected=44", outr); end
  endtask

  // Expected value = (reset value + enabled edges since last reset * step) mod 2**width.
  task automatic test_random;
    int k8, k4, kr;
    bit have8, have4, haver;
    logic [7:0] exp8, expr;
    logic [3:0] exp4;
    have8 = 0; have4 = 0; haver = 0;
    k8 = 0; k4 = 0; kr = 0;
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 15) == 0) || (i == 0);
      enable = $urandom_range(0, 3) != 0;
      r4     = ($urandom_range(0, 15) == 0) || (i == 0);
      e4     = $urandom_range(0, 1) != 0;
      rr     = ($urandom_range(0, 31) == 0) || (i == 0);
      er     = $urandom_range(0, 2) != 0;
      if (reset) begin k8 = 0; have8 = 1; end else if (enable) k8++;
      if (r4)    begin k4 = 0; have4 = 1; end else if (e4) k4++;
      if (rr)    begin kr = 0; haver = 1; end else if (er) kr++;
      cyc(1);
      exp8 = 8'((k8 * 1) % 256);
      exp4 = 4'((k4 * 3) % 16);
      expr = 8'((200 + kr) % 256);
      if (have8) begin
        checks++;
        if (out !== exp8) begin errors++; $display("FAIL rand8[%0d]: out=%0d expected=%0d", i, out, exp8); end
      end
      if (have4) begin
        checks++;
        if (out4 !== exp4) begin errors++; $display("FAIL rand4[%0d]: out=%0d expected=%0d", i, out4, exp4); end
      end
      if (haver) begin
        checks++;
        if (outr !== expr) begin errors++; $display("FAIL randrv[%0d]: out=%0d expected=%0d", i, outr, expr); end
      end
    end
    reset = 1'b0; enable = 1'b0; r4 = 1'b0; e4 = 1'b0; rr = 1'b0; er = 1'b0;
  endtask

  initial begin
    test_count_run();
    test_reset();
    test_hold();
    test_wrap();
    test_simultaneous();
    test_variants();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
